// File: rtl/ahb_req_scheduler_pkg.sv
// Shared types and bus constants for the two-requester AHB request scheduler.
package ahb_req_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } schedState_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
  } reqLatch_t;

endpackage

// File: rtl/ahb_req_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Set means requester 1 won most recently, so requester 0 owns the tie.
  logic lastGrant1;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant1 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      lastGrant1 <= 1'b1;
    else if (advance && (req != 2'b00))
      lastGrant1 <= grant[1];
  end

endmodule

// File: rtl/ahb_req_scheduler.sv
// Serialises two requesters onto one AHB master port, one non-pipelined transfer at a time.
module ahb_req_scheduler
  import ahb_req_scheduler_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [1:0]  iReq,
  input  logic [15:0] iAddr0,
  input  logic [15:0] iAddr1,
  input  logic        iWrite0,
  input  logic        iWrite1,
  input  logic [31:0] iWdata0,
  input  logic [31:0] iWdata1,
  output logic [1:0]  oAck,
  output logic [31:0] oRdata,
  output logic        oErr,
  output logic [1:0]  oGrant,
  output logic        oBusy,
  output logic        oHSEL,
  output logic [31:0] oHADDR,
  output logic [1:0]  oHTRANS,
  output logic        oHWRITE,
  output logic [31:0] oHWDATA,
  output logic        oHREADY,
  input  logic [31:0] iHRDATA,
  input  logic        iHREADYout,
  input  logic [1:0]  iHRESP
);

  schedState_t state, stateNext;
  logic [1:0]  grantQ, arbGrant;
  reqLatch_t   lat;
  logic [31:0] rdataQ;
  logic        errQ;
  logic        arbEn;

  assign arbEn = (state == ST_IDLE);

  rr_arb2 uArb (
    .clk     (iClk),
    .rst     (iRst),
    .req     (iReq),
    .advance (arbEn),
    .grant   (arbGrant)
  );

  always_ff @(posedge iClk) begin
    if (iRst) state <= ST_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (iReq != 2'b00) stateNext = ST_ADDR;
      ST_ADDR: if (iHREADYout)    stateNext = ST_DATA;
      ST_DATA: if (iHREADYout)    stateNext = ST_DONE;
      ST_DONE:                    stateNext = ST_IDLE;
      default:                    stateNext = ST_IDLE;
    endcase
  end

  // Response is only sampled on the ready cycle, so a two-cycle ERROR counts once.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      grantQ <= 2'b00;
      lat    <= '0;
      rdataQ <= 32'h0;
      errQ   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (iReq != 2'b00) begin
          grantQ <= arbGrant;
          lat    <= arbGrant[1] ? reqLatch_t'{iAddr1, iWrite1, iWdata1}
                                : reqLatch_t'{iAddr0, iWrite0, iWdata0};
        end
        ST_DATA: if (iHREADYout) begin
          rdataQ <= lat.write ? 32'h0 : iHRDATA;
          errQ   <= (iHRESP == HRESP_ERROR);
        end
        ST_DONE: grantQ <= 2'b00;
        default: ;
      endcase
    end
  end

  assign oGrant  = grantQ;
  assign oBusy   = (state != ST_IDLE);
  assign oAck    = (state == ST_DONE) ? grantQ : 2'b00;
  assign oErr    = (state == ST_DONE) && errQ;
  assign oRdata  = rdataQ;

  assign oHSEL   = (state == ST_ADDR);
  assign oHTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign oHADDR  = (state == ST_ADDR) ? (BASE_ADDR | {16'h0, lat.addr}) : 32'h0;
  assign oHWRITE = (state == ST_ADDR) && lat.write;
  assign oHWDATA = (state == ST_DATA) ? lat.wdata : 32'h0;
  assign oHREADY = iHREADYout;

endmodule

// File: tb/tb_ahb_req_scheduler.sv
// Directed vector bench for ahb_req_scheduler with a fixed-timeline slave model.
module tb_ahb_req_scheduler;
  import ahb_req_scheduler_pkg::*;

  logic        iClk, iRst;
  logic [1:0]  iReq;
  logic [15:0] iAddr0, iAddr1;
  logic        iWrite0, iWrite1;
  logic [31:0] iWdata0, iWdata1;
  logic [1:0]  oAck;
  logic [31:0] oRdata;
  logic        oErr;
  logic [1:0]  oGrant;
  logic        oBusy, oHSEL, oHWRITE, oHREADY;
  logic [31:0] oHADDR, oHWDATA;
  logic [1:0]  oHTRANS;
  logic [31:0] iHRDATA;
  logic        iHREADYout;
  logic [1:0]  iHRESP;

  ahb_req_scheduler dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq),
    .iAddr0(iAddr0), .iAddr1(iAddr1), .iWrite0(iWrite0), .iWrite1(iWrite1),
    .iWdata0(iWdata0), .iWdata1(iWdata1),
    .oAck(oAck), .oRdata(oRdata), .oErr(oErr), .oGrant(oGrant), .oBusy(oBusy),
    .oHSEL(oHSEL), .oHADDR(oHADDR), .oHTRANS(oHTRANS), .oHWRITE(oHWRITE),
    .oHWDATA(oHWDATA), .oHREADY(oHREADY),
    .iHRDATA(iHRDATA), .iHREADYout(iHREADYout), .iHRESP(iHRESP)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] addr0, addr1;
    logic [1:0]  wr;
    logic [31:0] wdata0, wdata1;
    int          aw, dw;
    logic [31:0] hrdata;
    logic [1:0]  respWait, respFinal, reqAfter, expGrant;
    logic        expWrite;
    logic [31:0] expHaddr, expWdata, expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[9];
  int nCmp = 0;
  int nMiss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " ack"},    oAck,    0);
    chk({tag, " err"},    oErr,    0);
    chk({tag, " rdata"},  oRdata,  0);
    chk({tag, " grant"},  oGrant,  0);
    chk({tag, " busy"},   oBusy,   0);
    chk({tag, " hsel"},   oHSEL,   0);
    chk({tag, " htrans"}, oHTRANS, 0);
    chk({tag, " haddr"},  oHADDR,  0);
    chk({tag, " hwrite"}, oHWRITE, 0);
    chk({tag, " hwdata"}, oHWDATA, 0);
  endtask

  // Entered and left in an IDLE cycle, 1 time unit after the edge.
  task automatic runVec(input int idx, input vec_t v);
    int ackAt;
    string t;
    ackAt = 3 + v.aw + v.dw;
    t = $sformatf("v%0d", idx);
    iReq = v.req; iAddr0 = v.addr0; iAddr1 = v.addr1;
    iWrite0 = v.wr[0]; iWrite1 = v.wr[1]; iWdata0 = v.wdata0; iWdata1 = v.wdata1;
    iHREADYout = 1'b1; iHRESP = HRESP_OKAY; iHRDATA = 32'h0;
    chk({t, " idle busy"}, oBusy, 0);
    for (int k = 1; k <= ackAt; k++) begin
      @(posedge iClk); #1;
      chk({t, " hready"}, oHREADY, iHREADYout);
      if (k == 1) begin
        iReq = v.reqAfter;
        iAddr0 = ~v.addr0; iAddr1 = ~v.addr1; iWdata0 = ~v.wdata0; iWdata1 = ~v.wdata1;
        iWrite0 = ~v.wr[0]; iWrite1 = ~v.wr[1];
      end
      if (k <= 1 + v.aw) begin
        chk({t, " addr hsel"},   oHSEL,   1);
        chk({t, " addr htrans"}, oHTRANS, 2'b10);
        chk({t, " addr haddr"},  oHADDR,  v.expHaddr);
        chk({t, " addr hwrite"}, oHWRITE, v.expWrite);
        chk({t, " addr grant"},  oGrant,  v.expGrant);
        chk({t, " addr ack"},    oAck,    0);
        iHREADYout = (k == 1 + v.aw);
      end else if (k < ackAt) begin
        chk({t, " data hsel"},   oHSEL,   0);
        chk({t, " data htrans"}, oHTRANS, 2'b00);
        chk({t, " data hwdata"}, oHWDATA, v.expWdata);
        chk({t, " data ack"},    oAck,    0);
        iHREADYout = (k == ackAt - 1);
        iHRDATA    = iHREADYout ? v.hrdata : 32'hDEAD_BEEF;
        iHRESP     = iHREADYout ? v.respFinal : v.respWait;
      end else begin
        chk({t, " done ack"},   oAck,   v.expGrant);
        chk({t, " done err"},   oErr,   v.expErr);
        chk({t, " done rdata"}, oRdata, v.expRdata);
        chk({t, " done busy"},  oBusy,  1);
        iHREADYout = 1'b1; iHRESP = HRESP_OKAY; iHRDATA = 32'h0;
      end
    end
    @(posedge iClk); #1;
    chk({t, " post ack"},   oAck,   0);
    chk({t, " post busy"},  oBusy,  0);
    chk({t, " post grant"}, oGrant, 0);
  endtask

  // Requester 0 wins, the bus stalls in DATA, and reset lands there.
  task automatic resetSeq();
    iReq = 2'b01; iAddr0 = 16'h0030; iWrite0 = 1'b0; iHREADYout = 1'b1;
    @(posedge iClk); #1;
    chk("rs addr grant", oGrant, 2'b01);
    @(posedge iClk); #1;
    chk("rs data busy", oBusy, 1);
    chk("rs data hsel", oHSEL, 0);
    iHREADYout = 1'b0; iRst = 1'b1; iReq = 2'b00;
    @(posedge iClk); #1;
    iRst = 1'b0;
    chkReset("rs");
    iHREADYout = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge iClk); #1;
      chk("rs no ack", oAck, 0);
      chk("rs idle", oBusy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{req:2'b01, addr0:16'h0010, addr1:16'h0, wr:2'b01, wdata0:32'hCAFE_F00D, wdata1:32'h0, aw:0, dw:0,
                hrdata:32'h55AA_55AA, respWait:2'b00, respFinal:2'b00, reqAfter:2'b00, expGrant:2'b01,
                expWrite:1'b1, expHaddr:32'h0000_0010, expWdata:32'hCAFE_F00D, expRdata:32'h0, expErr:1'b0};
    vecs[1] = '{req:2'b10, addr0:16'h0, addr1:16'h0020, wr:2'b00, wdata0:32'h0, wdata1:32'h0, aw:0, dw:2,
                hrdata:32'h1234_5678, respWait:2'b00, respFinal:2'b00, reqAfter:2'b00, expGrant:2'b10,
                expWrite:1'b0, expHaddr:32'h0000_0020, expWdata:32'h0, expRdata:32'h1234_5678, expErr:1'b0};
    vecs[2] = '{req:2'b01, addr0:16'h0104, addr1:16'h0, wr:2'b00, wdata0:32'h0, wdata1:32'h0, aw:0, dw:1,
                hrdata:32'hBAD0_BAD0, respWait:2'b01, respFinal:2'b01, reqAfter:2'b00, expGrant:2'b01,
                expWrite:1'b0, expHaddr:32'h0000_0104, expWdata:32'h0, expRdata:32'hBAD0_BAD0, expErr:1'b1};
    vecs[3] = '{req:2'b10, addr0:16'h0, addr1:16'hFFFE, wr:2'b10, wdata0:32'h0, wdata1:32'h0BAD_CAFE, aw:1, dw:1,
                hrdata:32'h7777_7777, respWait:2'b00, respFinal:2'b00, reqAfter:2'b00, expGrant:2'b10,
                expWrite:1'b1, expHaddr:32'h0000_FFFE, expWdata:32'h0BAD_CAFE, expRdata:32'h0, expErr:1'b0};
    vecs[4] = '{req:2'b01, addr0:16'h0200, addr1:16'h0, wr:2'b00, wdata0:32'h0, wdata1:32'h0, aw:0, dw:1,
                hrdata:32'h0F0F_0F0F, respWait:2'b01, respFinal:2'b00, reqAfter:2'b00, expGrant:2'b01,
                expWrite:1'b0, expHaddr:32'h0000_0200, expWdata:32'h0, expRdata:32'h0F0F_0F0F, expErr:1'b0};
    for (int i = 5; i < 9; i++) begin
      vecs[i] = '{req:2'b11, addr0:16'h1000, addr1:16'h2000, wr:2'b01, wdata0:32'h1111_1111, wdata1:32'h2222_2222,
                  aw:0, dw:0, hrdata:32'hA5A5_0000 + i, respWait:2'b00, respFinal:2'b00, reqAfter:2'b11,
                  expGrant:2'b01, expWrite:1'b1, expHaddr:32'h0000_1000, expWdata:32'h1111_1111,
                  expRdata:32'h0, expErr:1'b0};
    end
    vecs[6].expGrant = 2'b10; vecs[6].expWrite = 1'b0; vecs[6].expHaddr = 32'h0000_2000;
    vecs[6].expWdata = 32'h2222_2222; vecs[6].expRdata = 32'hA5A5_0006;
    vecs[8].expGrant = 2'b10; vecs[8].expWrite = 1'b0; vecs[8].expHaddr = 32'h0000_2000;
    vecs[8].expWdata = 32'h2222_2222; vecs[8].expRdata = 32'hA5A5_0008; vecs[8].reqAfter = 2'b00;

    iRst = 1'b1; iReq = 2'b00; iAddr0 = 16'h0; iAddr1 = 16'h0; iWrite0 = 1'b0; iWrite1 = 1'b0;
    iWdata0 = 32'h0; iWdata1 = 32'h0; iHRDATA = 32'h0; iHREADYout = 1'b1; iHRESP = HRESP_OKAY;
    repeat (2) @(posedge iClk);
    #1;
    chkReset("reset");
    iRst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (i == 5) resetSeq();
      runVec(i, vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nMiss);
    $finish;
  end

endmodule

// File: doc/ahb_req_scheduler.md
AHB_REQ_SCHEDULER -- requirements
Module: ahb_req_scheduler

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, OR'd onto the 16-bit requester address to form the AHB address.
REQ-002 SHALL have the port iClk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have the port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the port iReq, input, 2 bits: per-requester pending request (level).
REQ-005 SHALL have the port iAddr0/iAddr1, input, 16 bits each: requester byte address.
REQ-006 SHALL have the port iWrite0/iWrite1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have the port iWdata0/iWdata1, input, 32 bits each: write data.
REQ-008 SHALL have the port oAck, output, 2 bits: one-cycle completion pulse per requester.
REQ-009 SHALL have the port oRdata, output, 32 bits: read data, valid while any oAck bit is high.
REQ-010 SHALL have the port oErr, output, 1 bit: the transfer ended with an ERROR response; valid with oAck.
REQ-011 SHALL have the port oGrant, output, 2 bits: one-hot owner of the current transfer; 0 when idle.
REQ-012 SHALL have the port oBusy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have the AHB master ports oHSEL (1), oHADDR (32), oHTRANS (2), oHWRITE (1), oHWDATA (32) and oHREADY (1), all outputs.
REQ-014 SHALL have the AHB return ports iHRDATA (32), iHREADYout (1) and iHRESP (2), all inputs.

Function
REQ-015 SHALL implement an FSM with the states IDLE, ADDR, DATA and DONE.
REQ-016 SHALL, in IDLE with iReq != 0, grant one requester by round-robin, latch its address, write flag and wdata, and go to ADDR.
REQ-017 SHALL give priority in round-robin to the requester not granted last; after reset, requester 0 has priority.
REQ-018 SHALL, in IDLE with iReq == 0, stay in IDLE and drive oHSEL=0 and oHTRANS=IDLE (2'b00).
REQ-019 SHALL, in ADDR, drive the following address-phase signals:
- oHSEL=1
- oHTRANS=NONSEQ (2'b10)
- oHADDR = BASE_ADDR | {16'h0, latched addr}
- oHWRITE = latched write flag
REQ-020 SHALL leave ADDR for DATA only on a cycle where iHREADYout=1; otherwise it SHALL hold ADDR with all address-phase signals stable.
REQ-021 SHALL, in DATA, drive oHTRANS=IDLE, oHSEL=0, and oHWDATA = latched wdata, held stable until exit.
REQ-022 SHALL, in DATA on a cycle where iHREADYout=1, capture iHRDATA into oRdata and set the error flag = (iHRESP == 2'b01), then go to DONE.
REQ-023 SHALL, in DATA, ignore iHRESP on cycles where iHREADYout=0, so the first cycle of a two-cycle ERROR response is not captured.
REQ-024 SHALL, in DONE, assert oAck[granted]=1 and oErr for exactly one cycle, then return to IDLE.
REQ-025 SHALL keep oRdata at 0 when the completed transfer was a write.
REQ-026 SHALL drive oHREADY = iHREADYout combinationally (single slave on the bus).
REQ-027 SHALL complete a granted transfer even if its iReq drops mid-transfer; the ack is still issued.
REQ-028 SHALL rely on requesters clearing iReq on the clock edge at which they sample oAck=1; the following IDLE cycle then re-arbitrates with fresh requests.
REQ-029 SHALL, when both requests arrive in the same IDLE cycle, grant only one; the other waits at most one transfer.
REQ-030 SHALL have a minimum latency of 4 cycles from iReq seen in IDLE to oAck (IDLE, ADDR, DATA, DONE); each wait cycle adds 1.
REQ-031 SHALL NOT reach oHWDATA or oHADDR combinationally from the iAddr*/iWdata* ports.

Reset
REQ-032 SHALL, on iRst=1 at a clock edge, enter IDLE and hold these output values:
- oAck=0, oErr=0, oRdata=0, oGrant=0, oBusy=0
- oHSEL=0, oHTRANS=2'b00, oHADDR=0, oHWRITE=0, oHWDATA=0
- round-robin priority = requester 0
REQ-033 SHALL, on reset asserted mid-transfer, abandon the transfer with no oAck issued.

Structure
REQ-034 SHALL take the following from a shared package:
- FSM state encoding
- HTRANS constants IDLE=2'b00 and NONSEQ=2'b10
- HRESP constants OKAY=2'b00 and ERROR=2'b01
REQ-035 SHALL place the round-robin grant logic in one sub-module, rr_arb2: 2 requests in, one-hot grant out, last-grant register inside.

Verification
REQ-036 SHALL cover a single write: iReq=01, iAddr0=16'h0010, iWdata0=32'hCAFE_F00D, slave ready with no wait -> oHADDR=32'h0000_0010, oHWRITE=1, oHWDATA=CAFE_F00D, oAck=01 4 cycles after the request, oErr=0.
REQ-037 SHALL cover a read with waits: iReq=10, iAddr1=16'h0020, slave holds iHREADYout=0 for 2 DATA cycles then returns 32'h1234_5678 -> oAck=10 at cycle 6 with oRdata=32'h1234_5678.
REQ-038 SHALL cover simultaneous requests: iReq=11 right after reset -> requester 0 served first, then requester 1; with iReq kept at 11, grants alternate 0,1,0,1.
REQ-039 SHALL cover an error response: slave returns iHRESP=01 with HREADY 0 then 1 -> exactly one oAck pulse with oErr=1, and no capture on the HREADY=0 cycle.
REQ-040 SHALL cover reset during DATA: iRst=1 for one cycle -> all outputs at reset values, no oAck, next request granted to requester 0.
